// File: rtl/fifo_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter_if
//
// Bundles the requester-side handshake and the FIFO write port that the
// round-robin write arbiter sits between.
//
// Parameters
//   N       number of requesters (2..8)
//   DATA_W  data width per beat
//
// Signals
//   req_valid  [N]         requester i presents a beat
//   req_data   [N*DATA_W]  packed beats, requester i at [i*DATA_W +: DATA_W]
//   req_last   [N]         beat from requester i ends its burst
//   req_ready  [N]         one-hot or zero accept strobe back to requesters
//   fifo_full  [1]         FIFO cannot take a write this cycle
//   fifo_wen   [1]         FIFO write strobe
//   fifo_wdata [DATA_W]    FIFO write data (zero when fifo_wen is low)
//   grant_id   [clog2(N)]  index of the current grantee
//   busy       [1]         arbiter is in the middle of a grant
//
// Modports
//   master  environment side: requesters plus FIFO status
//   slave   arbiter side
// -----------------------------------------------------------------------------
interface fifo_write_arbiter_if #(
  parameter int N      = 4,
  parameter int DATA_W = 8
);
  localparam int GW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]        req_valid;
  logic [N*DATA_W-1:0] req_data;
  logic [N-1:0]        req_last;
  logic [N-1:0]        req_ready;
  logic                fifo_full;
  logic                fifo_wen;
  logic [DATA_W-1:0]   fifo_wdata;
  logic [GW-1:0]       grant_id;
  logic                busy;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    output fifo_full,
    input  req_ready,
    input  fifo_wen,
    input  fifo_wdata,
    input  grant_id,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    input  fifo_full,
    output req_ready,
    output fifo_wen,
    output fifo_wdata,
    output grant_id,
    output busy
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
//
// Round-robin arbiter sharing one FIFO write port among N requesters. A
// requester is granted for a burst that ends on its req_last beat or after
// MAX_BURST beats, whichever comes first. While the FIFO is full the grantee
// is backpressured through req_ready and the arbiter parks in HOLD.
//
// Parameters
//   N          number of requesters (2..8)
//   DATA_W     data width per beat
//   MAX_BURST  beat limit per grant (power of two, >= 2)
//
// Ports
//   clk   clock, all state updates on the rising edge
//   rstn  synchronous active-low reset
//   bus   fifo_write_arbiter_if.slave: requester handshake + FIFO write port
//
// State
//   r_state     IDLE / XFER / HOLD
//   r_ptr       round-robin start index for the next arbitration
//   r_grant_id  current grantee
//   r_cnt       beats already written in the current burst
// -----------------------------------------------------------------------------
module fifo_write_arbiter #(
  parameter int N         = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  fifo_write_arbiter_if.slave  bus
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(MAX_BURST);

  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
  localparam logic [GW-1:0] GID_LAST = GW'(N - 1);
  localparam logic [N-1:0]  ONE_HOT0 = N'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [GW-1:0] r_ptr;
  logic [GW-1:0] w_ptr_nxt;
  logic [GW-1:0] r_grant_id;
  logic [GW-1:0] w_grant_id_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  logic [GW-1:0]     w_sel;
  logic              w_any_valid;
  logic              w_gnt_valid;
  logic              w_gnt_last;
  logic [DATA_W-1:0] w_gnt_data;
  logic [N-1:0]      w_ready;
  logic              w_wen;
  logic              w_burst_end;

  // ---------------------------------------------------------------------------
  // State registers. All control state is reset; nothing on the data path is
  // registered, so fifo_wdata is a pure mux of the grantee's input.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  // Round-robin pick: first valid requester scanning r_ptr, r_ptr+1, ...,
  // wrapping through N-1 back to r_ptr-1. The modulo is done with a compare
  // and subtract because N need not be a power of two.
  always_comb begin
    logic found;
    int   idx;
    found       = 1'b0;
    idx         = 0;
    w_sel       = r_ptr;
    w_any_valid = |bus.req_valid;
    for (int k = 0; k < N; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        w_sel = GW'(idx);
      end
    end
  end

  // Grantee mux. Data only ever reaches fifo_wdata; it never feeds any
  // control decision.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_last  = 1'b0;
    w_gnt_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (r_grant_id == GW'(i)) begin
        w_gnt_valid = bus.req_valid[i];
        w_gnt_last  = bus.req_last[i];
        w_gnt_data  = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_grant_id_nxt = r_grant_id;
    w_cnt_nxt      = r_cnt;
    w_ready        = '0;
    w_wen          = 1'b0;
    w_burst_end    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_any_valid) begin
          w_grant_id_nxt = w_sel;
          w_cnt_nxt      = '0;
          w_state_nxt    = S_XFER;
        end
      end

      S_XFER: begin
        if (!bus.fifo_full) begin
          w_ready = ONE_HOT0 << r_grant_id;
        end
        // A grantee that drops valid mid-burst keeps the grant; nothing is
        // written and the beat count does not move.
        w_wen       = w_gnt_valid & ~bus.fifo_full;
        w_burst_end = w_wen & (w_gnt_last | (r_cnt == CNT_LAST));

        // Burst end is checked first: it can only happen on a write, and a
        // write implies the FIFO was not full, so it always wins.
        if (w_burst_end) begin
          w_ptr_nxt   = (r_grant_id == GID_LAST) ? '0 : r_grant_id + GW'(1);
          w_state_nxt = S_IDLE;
        end else if (bus.fifo_full) begin
          w_state_nxt = S_HOLD;
        end else if (w_wen) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      S_HOLD: begin
        if (!bus.fifo_full) begin
          w_state_nxt = S_XFER;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.req_ready  = w_ready;
  assign bus.fifo_wen   = w_wen;
  assign bus.fifo_wdata = w_wen ? w_gnt_data : '0;
  assign bus.grant_id   = r_grant_id;
  assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_write_arbiter
//
// Randomized bench for fifo_write_arbiter. Each requester owns a stream of
// beats (random data, random last flag); a beat is held until accepted. The
// reference model tracks the arbiter as "who owns the port, how many beats
// it has written, is it stalled" and predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_fifo_write_arbiter;

  localparam int N         = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 16;
  localparam int GW        = 2;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.N(N), .DATA_W(DATA_W)) bus ();

  fifo_write_arbiter #(
    .N         (N),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Pending beat per requester, held until accepted.
  logic [DATA_W-1:0] b_data [N];
  bit                b_last [N];

  // Reference model: owner -1 means nobody holds the port.
  int m_owner;
  int m_ptr;
  int m_gid;
  int m_beats;
  bit m_stall;

  // Per-phase stimulus shape.
  typedef struct {
    logic [N-1:0] mask;
    int valid_pct;
    int full_pct;
    int last_pct;
    int rst_pct;
    int cycles;
  } phase_t;

  phase_t phases [7];

  task automatic new_beat(input int i, input int last_pct);
    b_data[i] = DATA_W'($urandom);
    b_last[i] = ($urandom_range(0, 99) < last_pct);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_gid   = 0;
    m_beats = 0;
    m_stall = 1'b0;
  endtask

  task automatic run_cycle(input phase_t ph);
    logic [N-1:0]        exp_ready;
    logic                exp_wen;
    logic [DATA_W-1:0]   exp_wdata;
    logic [N*DATA_W-1:0] packed_data;

    // Drive this cycle's inputs.
    rstn = !($urandom_range(0, 999) < ph.rst_pct * 10);
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = ph.mask[i] && ($urandom_range(0, 99) < ph.valid_pct);
      bus.req_last[i]  = b_last[i];
      packed_data[i*DATA_W +: DATA_W] = b_data[i];
    end
    bus.req_data  = packed_data;
    bus.fifo_full = ($urandom_range(0, 99) < ph.full_pct);

    @(negedge clk);

    // Prediction from the model's view of who owns the port.
    exp_ready = '0;
    exp_wen   = 1'b0;
    exp_wdata = '0;
    if (m_owner >= 0 && !m_stall) begin
      if (!bus.fifo_full) exp_ready[m_owner] = 1'b1;
      exp_wen = bus.req_valid[m_owner] && !bus.fifo_full;
      if (exp_wen) exp_wdata = b_data[m_owner];
    end

    check_val("req_ready",  32'(bus.req_ready),  32'(exp_ready));
    check_val("fifo_wen",   32'(bus.fifo_wen),   32'(exp_wen));
    check_val("fifo_wdata", 32'(bus.fifo_wdata), 32'(exp_wdata));
    check_val("grant_id",   32'(bus.grant_id),   32'(m_gid));
    check_val("busy",       32'(bus.busy),       32'(m_owner >= 0));
    if (bus.fifo_full) check_val("no_write_when_full", 32'(bus.fifo_wen), 32'd0);

    // Advance the model to the next cycle.
    if (exp_wen) new_beat(m_owner, ph.last_pct);
    if (!rstn) begin
      model_reset();
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (m_owner < 0 && bus.req_valid[j]) m_owner = j;
      end
      if (m_owner >= 0) begin
        m_gid   = m_owner;
        m_beats = 0;
      end
    end else if (m_stall) begin
      if (!bus.fifo_full) m_stall = 1'b0;
    end else begin
      if (exp_wen) begin
        m_beats++;
        if (bus.req_last[m_owner] || m_beats == MAX_BURST) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end else if (bus.fifo_full) begin
        m_stall = 1'b1;
      end
    end

    @(posedge clk);
    #1;
  endtask

  initial begin
    // mask, valid%, full%, last%, reset%, cycles
    phases[0] = '{4'b0100, 100,  0,  35, 0,   40};   // single requester 2
    phases[1] = '{4'b1111, 100,  0, 100, 0,   40};   // 1-beat round robin
    phases[2] = '{4'b0010, 100,  0,   0, 0,   60};   // beat limit, re-grant
    phases[3] = '{4'b0110, 100,  0,   0, 0,   80};   // beat limit, hand-off
    phases[4] = '{4'b1111,  90, 45,  20, 0,  600};   // heavy backpressure
    phases[5] = '{4'b1111,  60, 20,  25, 2, 2500};   // everything + resets
    phases[6] = '{4'b1011,  70, 30,   0, 0,  600};   // long bursts, gaps

    for (int i = 0; i < N; i++) new_beat(i, 30);
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    rstn          = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset state, before any traffic.
    check_val("rst_busy",      32'(bus.busy),       32'd0);
    check_val("rst_grant_id",  32'(bus.grant_id),   32'd0);
    check_val("rst_req_ready", 32'(bus.req_ready),  32'd0);
    check_val("rst_fifo_wen",  32'(bus.fifo_wen),   32'd0);
    check_val("rst_wdata",     32'(bus.fifo_wdata), 32'd0);

    for (int p = 0; p < 7; p++) begin
      for (int c = 0; c < phases[p].cycles; c++) run_cycle(phases[p]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write-port arbiter that shares a single FIFO write interface between N requesters. It grants one requester at a time for a burst (terminated by `req_last` or a beat limit), forwards that requester's data to the FIFO, and backpressures through per-requester `req_ready` while the FIFO is full. It sits directly in front of the FIFO and its controller in the write-side datapath.

## Interface
- `N`, 4: number of requesters (2..8).
- `DATA_W`, 8: data width per beat.
- `MAX_BURST`, 16: maximum beats per grant (power of two, ≥2).
- `clk`  in  1  clock, all state on rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `req_valid`  in  N  requester i has a beat on `req_data[i*DATA_W +: DATA_W]`.
- `req_data`  in  N*DATA_W  packed requester data.
- `req_last`  in  N  beat from requester i is the last of its burst.
- `req_ready`  out  N  one-hot or zero; beat from i accepted when `req_valid[i] & req_ready[i]`.
- `fifo_full`  in  1  FIFO cannot accept a write this cycle.
- `fifo_wen`  out  1  write strobe to FIFO.
- `fifo_wdata`  out  DATA_W  write data to FIFO.
- `grant_id`  out  clog2(N)  index of current grantee (registered).
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, XFER, HOLD. Registers: `grant_id`, round-robin pointer `ptr` (clog2(N)), beat counter `cnt` (clog2(MAX_BURST)).
- IDLE: if any `req_valid`, select first set index scanning ptr, ptr+1, …, N-1, 0, …, ptr-1; load `grant_id`, clear `cnt`, go XFER. Else stay.
- XFER: `req_ready[grant_id] = !fifo_full`, all other ready bits 0. `fifo_wen = req_valid[grant_id] & !fifo_full`; `fifo_wdata = req_data` slice of `grant_id`. On a transfer `cnt` increments.
- Burst end: transfer with `req_last[grant_id]=1` or with `cnt == MAX_BURST-1`. Then `ptr <= grant_id+1` (wraps N-1 → 0), go IDLE.
- XFER with `fifo_full=1` (and no burst end): go HOLD. Burst end takes priority over fullness.
- HOLD: all `req_ready` 0, `fifo_wen` 0; go XFER when `fifo_full=0`, else stay. `cnt`, `grant_id` held.
- Grantee dropping `req_valid` mid-burst: grant kept, no write, no counter change (no timeout).
- `fifo_wdata` driven 0 when `fifo_wen`=0.
- No write is ever issued while `fifo_full=1`.

## Timing
- Reset (rstn low at a clock edge): state IDLE, `ptr`=0, `grant_id`=0, `cnt`=0; outputs `req_ready`=0, `fifo_wen`=0, `fifo_wdata`=0, `busy`=0. Reset mid-burst aborts it; no write the following cycle.
- Arbitration latency: `req_valid` seen in IDLE at cycle t, earliest transfer in cycle t+1.
- One IDLE bubble cycle between consecutive bursts, always.
- `req_ready`/`fifo_wen` combinational from state, `grant_id`, `req_valid`, `fifo_full`; no combinational path from `req_data` to control.
- HOLD exit: `fifo_full` falls in cycle t, state XFER in t+1, first write in t+1.
- Max burst: exactly MAX_BURST writes per grant when `req_last` never asserted.

## Test plan
- Single requester: N=4, only req 2 valid, 3 beats with last on 3rd, FIFO never full -> grant_id=2 after 1 cycle, 3 consecutive `fifo_wen` pulses with matching data, IDLE, ptr=3.
- Round-robin fairness: all 4 valid continuously, 1-beat bursts -> grant order 0,1,2,3,0, one IDLE cycle between each, wrap of ptr 3→0.
- Beat limit: req 1 streams 20 beats, never last, MAX_BURST=16 -> exactly 16 writes, IDLE, req 2 (if valid) granted next, else req 1 re-granted for remaining 4.
- Backpressure: `fifo_full` high for 3 cycles mid-burst -> `req_ready`=0, `fifo_wen`=0 in all full cycles, HOLD entered, writes resume one cycle after full falls, no beat lost or duplicated.
- Full on last beat: `fifo_full`=1 while grantee presents last -> no transfer, HOLD; after full falls, last beat written, then IDLE.
- Reset mid-burst: rstn low for 1 cycle during beat 2 of 5 -> next cycle all outputs 0, busy=0, ptr=0; new arbitration starts from index 0.
